// File: rtl/dp_aux_arbiter.sv
`timescale 1ns/1ps
// Source-side AUX controller: round-robin arbitration between two requesters, one
// framed request per transaction, reply collection with DEFER retry, timeout and HPD abort.
module dp_aux_arbiter #(
    parameter int AUX_ADDRESS_WIDTH = 20,
    parameter int AUX_DATA_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES    = 400,
    parameter int MAX_RETRY         = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         hpd_signal,
    input  logic                         req0_valid,
    input  logic [3:0]                   req0_cmd,
    input  logic [AUX_ADDRESS_WIDTH-1:0] req0_addr,
    input  logic [3:0]                   req0_len,
    input  logic [AUX_DATA_WIDTH-1:0]    req0_wr_data,
    output logic                         req0_ready,
    output logic                         req0_wr_pop,
    input  logic                         req1_valid,
    input  logic [3:0]                   req1_cmd,
    input  logic [AUX_ADDRESS_WIDTH-1:0] req1_addr,
    input  logic [3:0]                   req1_len,
    input  logic [AUX_DATA_WIDTH-1:0]    req1_wr_data,
    output logic                         req1_ready,
    output logic                         req1_wr_pop,
    output logic [AUX_DATA_WIDTH-1:0]    aux_out,
    output logic                         aux_start_stop,
    input  logic [AUX_DATA_WIDTH-1:0]    aux_in,
    input  logic                         phy_start_stop,
    output logic                         rsp_id,
    output logic [AUX_DATA_WIDTH-1:0]    rsp_data,
    output logic                         rsp_vld,
    output logic                         rsp_done,
    output logic [1:0]                   rsp_status,
    output logic [4:0]                   rsp_bytes,
    output logic                         busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    localparam logic [1:0] RP_ACK   = 2'b00;
    localparam logic [1:0] RP_DEFER = 2'b10;

    localparam logic [1:0] ST_ACK   = 2'b00;
    localparam logic [1:0] ST_NACK  = 2'b01;
    localparam logic [1:0] ST_DEFER = 2'b10;
    localparam logic [1:0] ST_ABORT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_HDR,
        S_SEND_DATA,
        S_WAIT_REPLY,
        S_RECV,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]                   req_valid;
    logic [3:0]                   cmd_in     [2];
    logic [AUX_ADDRESS_WIDTH-1:0] addr_in    [2];
    logic [3:0]                   len_in     [2];
    logic [AUX_DATA_WIDTH-1:0]    wr_data_in [2];
    logic [1:0]                   ready_vec;
    logic [1:0]                   pop_vec;

    logic                         id_reg;
    logic                         last_reg;
    logic [3:0]                   cmd_reg;
    logic [AUX_ADDRESS_WIDTH-1:0] addr_reg;
    logic [3:0]                   len_reg;
    logic [3:0]                   byte_idx_reg;
    logic [TW-1:0]                tmo_reg;
    logic [RW-1:0]                retry_reg, retry_next;
    logic [1:0]                   status_reg, status_next;
    logic [1:0]                   reply_reg;
    logic [4:0]                   rx_cnt_reg;
    logic [AUX_DATA_WIDTH-1:0]    rsp_data_reg;
    logic                         rsp_vld_reg;

    logic [AUX_DATA_WIDTH-1:0]    wbuf [16];
    logic [AUX_DATA_WIDTH-1:0]    buf_rd_reg;
    logic [3:0]                   buf_rd_addr;
    logic                         wbuf_we;

    logic                         grant;
    logic                         grant_id;
    logic                         first_try;
    logic                         pop_en;
    logic                         deliver;
    logic [AUX_DATA_WIDTH-1:0]    hdr_byte;
    logic [AUX_DATA_WIDTH-1:0]    wr_sel;

    assign req_valid     = {req1_valid, req0_valid};
    assign cmd_in[0]     = req0_cmd;
    assign cmd_in[1]     = req1_cmd;
    assign addr_in[0]    = req0_addr;
    assign addr_in[1]    = req1_addr;
    assign len_in[0]     = req0_len;
    assign len_in[1]     = req1_len;
    assign wr_data_in[0] = req0_wr_data;
    assign wr_data_in[1] = req1_wr_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign ready_vec[gi] = grant && (grant_id == 1'(gi));
            assign pop_vec[gi]   = pop_en && (id_reg == 1'(gi));
        end
    endgenerate

    assign req0_ready  = ready_vec[0];
    assign req1_ready  = ready_vec[1];
    assign req0_wr_pop = pop_vec[0];
    assign req1_wr_pop = pop_vec[1];

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant    = 1'b0;
        grant_id = 1'b0;
        if (!rst && state_reg == S_IDLE && hpd_signal && (|req_valid)) begin
            grant = 1'b1;
            if (&req_valid)
                grant_id = ~last_reg;
            else
                grant_id = req_valid[1];
        end
    end

    assign first_try = (retry_reg == '0);
    assign wr_sel    = wr_data_in[id_reg];

    always_comb begin
        hdr_byte = '0;
        case (byte_idx_reg[1:0])
            2'd0:    hdr_byte = AUX_DATA_WIDTH'({cmd_reg, addr_reg[19:16]});
            2'd1:    hdr_byte = AUX_DATA_WIDTH'(addr_reg[15:8]);
            2'd2:    hdr_byte = AUX_DATA_WIDTH'(addr_reg[7:0]);
            default: hdr_byte = AUX_DATA_WIDTH'({4'b0000, len_reg});
        endcase
    end

    assign deliver = (state_reg == S_RECV) && hpd_signal && phy_start_stop &&
                     (reply_reg == RP_ACK) && cmd_reg[0] &&
                     (rx_cnt_reg < ({1'b0, len_reg} + 5'd1));

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        status_next = status_reg;
        retry_next  = retry_reg;
        case (state_reg)
            S_IDLE: begin
                if (grant) begin
                    state_next  = S_SEND_HDR;
                    status_next = ST_ACK;
                    retry_next  = '0;
                end
            end
            S_SEND_HDR: begin
                if (byte_idx_reg == 4'd3)
                    state_next = cmd_reg[0] ? S_WAIT_REPLY : S_SEND_DATA;
            end
            S_SEND_DATA: begin
                if (byte_idx_reg == len_reg)
                    state_next = S_WAIT_REPLY;
            end
            S_WAIT_REPLY: begin
                if (phy_start_stop) begin
                    state_next = S_RECV;
                end else if (tmo_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_next  = S_DONE;
                    status_next = ST_ABORT;
                end
            end
            S_RECV: begin
                if (!phy_start_stop) begin
                    state_next = S_DONE;
                    if (reply_reg == RP_ACK) begin
                        status_next = ST_ACK;
                    end else if (reply_reg == RP_DEFER) begin
                        if (retry_reg < RW'(MAX_RETRY)) begin
                            retry_next = retry_reg + RW'(1);
                            state_next = S_SEND_HDR;
                        end else begin
                            status_next = ST_DEFER;
                        end
                    end else begin
                        status_next = ST_NACK;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // Losing the sink overrides whatever the active phase decided.
        if (state_reg != S_IDLE && state_reg != S_DONE && !hpd_signal) begin
            state_next  = S_DONE;
            status_next = ST_ABORT;
            retry_next  = retry_reg;
        end
    end

    always_comb begin
        aux_out        = '0;
        aux_start_stop = 1'b0;
        pop_en         = 1'b0;
        wbuf_we        = 1'b0;
        buf_rd_addr    = '0;
        case (state_reg)
            S_SEND_HDR: begin
                if (hpd_signal) begin
                    aux_start_stop = 1'b1;
                    aux_out        = hdr_byte;
                end
            end
            S_SEND_DATA: begin
                // Prefetch the next byte so a retry streams from the buffer without gaps.
                buf_rd_addr = byte_idx_reg + 4'd1;
                if (hpd_signal) begin
                    aux_start_stop = 1'b1;
                    aux_out        = first_try ? wr_sel : buf_rd_reg;
                    pop_en         = first_try;
                    wbuf_we        = first_try;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wbuf_we)
            wbuf[byte_idx_reg] <= wr_sel;
        buf_rd_reg <= wbuf[buf_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_reg       <= 1'b0;
            last_reg     <= 1'b1;
            cmd_reg      <= '0;
            addr_reg     <= '0;
            len_reg      <= '0;
            byte_idx_reg <= '0;
            tmo_reg      <= '0;
            retry_reg    <= '0;
            status_reg   <= '0;
            reply_reg    <= '0;
            rx_cnt_reg   <= '0;
            rsp_data_reg <= '0;
            rsp_vld_reg  <= 1'b0;
        end else begin
            if (grant) begin
                id_reg   <= grant_id;
                cmd_reg  <= cmd_in[grant_id];
                addr_reg <= addr_in[grant_id];
                len_reg  <= len_in[grant_id];
            end
            byte_idx_reg <= (state_next == state_reg &&
                             (state_reg == S_SEND_HDR || state_reg == S_SEND_DATA)) ?
                            byte_idx_reg + 4'd1 : 4'd0;
            tmo_reg      <= (state_reg == S_WAIT_REPLY && state_next == S_WAIT_REPLY) ?
                            tmo_reg + TW'(1) : '0;
            retry_reg    <= retry_next;
            status_reg   <= status_next;
            if (state_reg == S_WAIT_REPLY && phy_start_stop)
                reply_reg <= aux_in[5:4];
            if (grant || (state_reg != S_WAIT_REPLY && state_next == S_WAIT_REPLY))
                rx_cnt_reg <= '0;
            else if (deliver)
                rx_cnt_reg <= rx_cnt_reg + 5'd1;
            rsp_vld_reg <= deliver;
            if (deliver)
                rsp_data_reg <= aux_in;
            if (state_reg == S_DONE)
                last_reg <= id_reg;
        end
    end

    assign rsp_done   = (state_reg == S_DONE);
    assign rsp_status = rsp_done ? status_reg : 2'b00;
    assign rsp_bytes  = rsp_done ? rx_cnt_reg : 5'd0;
    assign rsp_id     = grant ? grant_id : id_reg;
    assign rsp_data   = rsp_data_reg;
    assign rsp_vld    = rsp_vld_reg;
    assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_dp_aux_arbiter.sv
`timescale 1ns/1ps
// Directed bench for dp_aux_arbiter: read reply, round-robin, write with DEFER
// retries, DEFER exhaustion, reply timeout, HPD abort and mid-transaction reset.
module tb_dp_aux_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        hpd_signal;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_cmd, req1_cmd;
    logic [19:0] req0_addr, req1_addr;
    logic [3:0]  req0_len, req1_len;
    logic [7:0]  req0_wr_data, req1_wr_data;
    logic        req0_ready, req1_ready;
    logic        req0_wr_pop, req1_wr_pop;
    logic [7:0]  aux_out;
    logic        aux_start_stop;
    logic [7:0]  aux_in;
    logic        phy_start_stop;
    logic        rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_vld;
    logic        rsp_done;
    logic [1:0]  rsp_status;
    logic [4:0]  rsp_bytes;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int done_at;
    logic [7:0] wd [3];

    dp_aux_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .hpd_signal     (hpd_signal),
        .req0_valid     (req0_valid),
        .req0_cmd       (req0_cmd),
        .req0_addr      (req0_addr),
        .req0_len       (req0_len),
        .req0_wr_data   (req0_wr_data),
        .req0_ready     (req0_ready),
        .req0_wr_pop    (req0_wr_pop),
        .req1_valid     (req1_valid),
        .req1_cmd       (req1_cmd),
        .req1_addr      (req1_addr),
        .req1_len       (req1_len),
        .req1_wr_data   (req1_wr_data),
        .req1_ready     (req1_ready),
        .req1_wr_pop    (req1_wr_pop),
        .aux_out        (aux_out),
        .aux_start_stop (aux_start_stop),
        .aux_in         (aux_in),
        .phy_start_stop (phy_start_stop),
        .rsp_id         (rsp_id),
        .rsp_data       (rsp_data),
        .rsp_vld        (rsp_vld),
        .rsp_done       (rsp_done),
        .rsp_status     (rsp_status),
        .rsp_bytes      (rsp_bytes),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hdr_check(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] e [4];
        e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk(tag, {23'd0, aux_start_stop, aux_out}, {24'd1, e[i]});
        end
    endtask

    task automatic defer_reply();
        @(negedge clk); phy_start_stop = 1'b1; aux_in = 8'h20; #1;
        chk("defer_wait_quiet", aux_start_stop, 1'b0);
        @(negedge clk); phy_start_stop = 1'b0; aux_in = 8'h00; #1;
    endtask

    task automatic write_attempt(input logic first, input logic [7:0] reply);
        hdr_check("wr_hdr", 8'h80, 8'h02, 8'h00, 8'h02);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req1_wr_data = first ? wd[i] : 8'hEE;
            #1;
            chk("wr_pop", req1_wr_pop, first);
            chk("wr_byte", {23'd0, aux_start_stop, aux_out}, {24'd1, wd[i]});
        end
        @(negedge clk); phy_start_stop = 1'b1; aux_in = reply; #1;
        chk("wr_wait_quiet", aux_start_stop, 1'b0);
        if (reply[5:4] == 2'b00) begin
            @(negedge clk); aux_in = 8'h77; #1;
        end
        @(negedge clk); phy_start_stop = 1'b0; aux_in = 8'h00; #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; hpd_signal = 1'b0;
        req0_valid = 1'b0; req0_cmd = '0; req0_addr = '0; req0_len = '0; req0_wr_data = '0;
        req1_valid = 1'b0; req1_cmd = '0; req1_addr = '0; req1_len = '0; req1_wr_data = '0;
        aux_in = '0; phy_start_stop = 1'b0;
        wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_aux", {aux_start_stop, aux_out}, 9'd0);
        chk("rst_rsp", {rsp_done, rsp_vld, rsp_status, rsp_bytes, rsp_id}, 11'd0);
        @(negedge clk); rst = 1'b0; hpd_signal = 1'b1;

        // Native read of two bytes by req0
        @(negedge clk);
        req0_valid = 1'b1; req0_cmd = 4'h9; req0_addr = 20'h00100; req0_len = 4'd1; #1;
        chk("t1_ready0", req0_ready, 1'b1);
        chk("t1_rsp_id", rsp_id, 1'b0);
        @(posedge clk); #1; req0_valid = 1'b0;
        hdr_check("t1_hdr", 8'h90, 8'h01, 8'h00, 8'h01);
        @(negedge clk); phy_start_stop = 1'b1; aux_in = 8'h00; #1;
        chk("t1_wait_quiet", aux_start_stop, 1'b0);
        chk("t1_busy", busy, 1'b1);
        @(negedge clk); aux_in = 8'hAA; #1;
        @(negedge clk); aux_in = 8'h55; #1;
        chk("t1_data0", {rsp_vld, rsp_data}, {1'b1, 8'hAA});
        @(negedge clk); phy_start_stop = 1'b0; aux_in = 8'h00; #1;
        chk("t1_data1", {rsp_vld, rsp_data}, {1'b1, 8'h55});
        @(negedge clk); #1;
        chk("t1_done", {rsp_done, rsp_status, rsp_bytes}, {1'b1, 2'b00, 5'd2});
        chk("t1_vld_off", rsp_vld, 1'b0);
        @(negedge clk); #1;
        chk("t1_idle", {busy, rsp_done}, 2'b00);

        // Round-robin from a fresh reset: req0 first, then req1
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        chk("t2_rst_busy", busy, 1'b0);
        @(negedge clk);
        req0_valid = 1'b1; req0_cmd = 4'h9; req0_addr = 20'h12345; req0_len = 4'd0;
        req1_valid = 1'b1; req1_cmd = 4'h8; req1_addr = 20'h00200; req1_len = 4'd2;
        req1_wr_data = wd[0]; #1;
        chk("t2_tie_ready0", req0_ready, 1'b1);
        chk("t2_tie_ready1", req1_ready, 1'b0);
        chk("t2_tie_rsp_id", rsp_id, 1'b0);
        @(posedge clk); #1; req0_valid = 1'b0;
        hdr_check("t2_hdr", 8'h91, 8'h23, 8'h45, 8'h00);
        chk("t2_busy_ignores_req1", req1_ready, 1'b0);
        @(negedge clk); phy_start_stop = 1'b1; aux_in = 8'h10; #1;
        @(negedge clk); phy_start_stop = 1'b0; aux_in = 8'h00; #1;
        @(negedge clk); #1;
        chk("t2_nack_done", {rsp_done, rsp_status, rsp_bytes}, {1'b1, 2'b01, 5'd0});
        chk("t2_nack_id", rsp_id, 1'b0);
        @(negedge clk); req0_valid = 1'b1; #1;
        chk("t2_rr_ready1", req1_ready, 1'b1);
        chk("t2_rr_ready0", req0_ready, 1'b0);
        chk("t2_rr_rsp_id", rsp_id, 1'b1);
        @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;

        // req1 write: DEFER, DEFER, ACK (with a stray reply byte)
        write_attempt(1'b1, 8'h20);
        write_attempt(1'b0, 8'h20);
        write_attempt(1'b0, 8'h00);
        @(negedge clk); #1;
        chk("t3_done", {rsp_done, rsp_status, rsp_bytes}, {1'b1, 2'b00, 5'd0});
        chk("t3_id", rsp_id, 1'b1);
        chk("t3_no_vld", rsp_vld, 1'b0);

        // Four DEFERs exhaust the retries
        @(negedge clk);
        req0_valid = 1'b1; req0_cmd = 4'h9; req0_addr = 20'h00000; req0_len = 4'd0; #1;
        chk("t4_ready0", req0_ready, 1'b1);
        @(posedge clk); #1; req0_valid = 1'b0;
        for (int a = 0; a < 4; a++) begin
            hdr_check("t4_hdr", 8'h90, 8'h00, 8'h00, 8'h00);
            defer_reply();
        end
        @(negedge clk); #1;
        chk("t4_done", {rsp_done, rsp_status, rsp_bytes}, {1'b1, 2'b10, 5'd0});

        // Silent sink: timeout
        @(negedge clk);
        req0_valid = 1'b1; req0_cmd = 4'h9; req0_addr = 20'h00300; req0_len = 4'd0; #1;
        chk("t5_ready0", req0_ready, 1'b1);
        @(posedge clk); #1; req0_valid = 1'b0;
        hdr_check("t5_hdr", 8'h90, 8'h03, 8'h00, 8'h00);
        done_at = 0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk); #1;
            if (rsp_done) begin
                done_at = k;
                break;
            end
        end
        chk("t5_timeout_latency", done_at, 401);
        chk("t5_status", {rsp_status, rsp_bytes}, {2'b11, 5'd0});

        // HPD loss during SEND_DATA
        @(negedge clk);
        req1_valid = 1'b1; req1_cmd = 4'h8; req1_addr = 20'h00400; req1_len = 4'd3;
        req1_wr_data = 8'hA0; #1;
        chk("t6_ready1", req1_ready, 1'b1);
        @(posedge clk); #1; req1_valid = 1'b0;
        hdr_check("t6_hdr", 8'h80, 8'h04, 8'h00, 8'h03);
        @(negedge clk); #1;
        chk("t6_pop", {req1_wr_pop, aux_start_stop, aux_out}, {1'b1, 1'b1, 8'hA0});
        @(negedge clk); hpd_signal = 1'b0; #1;
        @(negedge clk); #1;
        chk("t6_ss_drop", aux_start_stop, 1'b0);
        chk("t6_abort_done", {rsp_done, rsp_status}, {1'b1, 2'b11});
        @(negedge clk);
        req0_valid = 1'b1; req0_cmd = 4'h9; req0_addr = 20'h00000; req0_len = 4'd0; #1;
        chk("t6_no_ready_hpd_low", {req0_ready, busy}, 2'b00);
        @(negedge clk); #1;
        chk("t6_still_no_ready", req0_ready, 1'b0);
        @(negedge clk); hpd_signal = 1'b1; #1;
        chk("t6_ready_hpd_back", req0_ready, 1'b1);
        @(posedge clk); #1; req0_valid = 1'b0;

        // Reset in the middle of a header
        @(negedge clk); #1;
        chk("t7_busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        chk("t7_rst_idle", {busy, aux_start_stop, rsp_done}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dp_aux_arbiter.md
Name: dp_aux_arbiter

Overview:
- Source-side AUX channel controller that shares the single AUX byte path between two requesters: req0 (link-training engine) and req1 (general DPCD/EDID access).
- Arbitrates, serializes one request into an AUX frame (one byte per clock, framed by aux_start_stop), then waits for the sink reply framed by phy_start_stop.
- Retries on DEFER, times out on silence, aborts on HPD loss, and returns reply data and status to the granted requester.

Parameters:
- AUX_ADDRESS_WIDTH, 20, DPCD address width (fixed 20; bytes 0..2 of the header carry it).
- AUX_DATA_WIDTH, 8, AUX byte width.
- TIMEOUT_CYCLES, 400, clocks allowed from the last transmitted byte to the first reply byte.
- MAX_RETRY, 3, number of re-sends after a DEFER reply.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- hpd_signal  in  1  sink connected when high
- req0_valid / req1_valid  in  1  request pending
- req0_cmd / req1_cmd  in  4  AUX command; cmd[0]=1 read, 0 write
- req0_addr / req1_addr  in  20  DPCD address
- req0_len / req1_len  in  4  payload length minus 1 (1..16 bytes)
- req0_wr_data / req1_wr_data  in  8  write byte, first-word-fall-through
- req0_ready / req1_ready  out  1  one-cycle accept pulse
- req0_wr_pop / req1_wr_pop  out  1  write byte consumed this cycle
- aux_out  out  8  transmitted byte
- aux_start_stop  out  1  high on every cycle aux_out carries a frame byte
- aux_in  in  8  reply byte
- phy_start_stop  in  1  high on every cycle aux_in is valid
- rsp_id  out  1  requester owning the rsp_* outputs
- rsp_data  out  8  read reply byte
- rsp_vld  out  1  rsp_data valid
- rsp_done  out  1  one-cycle transaction-complete pulse
- rsp_status  out  2  00 ACK, 01 NACK, 10 DEFER-exhausted, 11 TIMEOUT/ABORT
- rsp_bytes  out  5  reply data bytes delivered; valid with rsp_done
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE.
  - The last-grant register is 1, so req0 wins the first tie.
  - Retry counter, timeout counter and write buffer pointers are cleared.
- Arbitration (IDLE):
  - A grant is issued only when hpd_signal=1 and at least one reqN_valid=1.
  - A single pending requester is granted directly.
  - When both are pending, the requester not granted last wins (round-robin).
  - reqN_ready pulses in the grant cycle; cmd, addr, len and the id are latched.
  - rsp_id takes the granted id in the grant cycle.
  - Requests are ignored while busy.
- SEND_HDR:
  - Starts the cycle after the grant and lasts 4 consecutive cycles with aux_start_stop=1.
  - Bytes in order: {cmd,addr[19:16]}, addr[15:8], addr[7:0], {4'b0,len}.
- SEND_DATA (writes only):
  - Exactly len+1 further contiguous cycles with aux_start_stop held high.
  - First attempt: reqN_wr_pop=1 each cycle; aux_out=reqN_wr_data, and the byte is stored in a 16x8 buffer.
  - Retries: bytes come from the buffer and wr_pop stays 0.
  - Reads skip SEND_DATA.
- WAIT_REPLY:
  - aux_start_stop=0 and the timeout counter runs.
  - The first cycle with phy_start_stop=1 enters RECV and that byte is the reply command.
  - Reply code is aux_in[5:4]: 00 ACK, 01 NACK, 10 DEFER.
  - If the count reaches TIMEOUT_CYCLES, finish with status 11 and no retry.
- RECV:
  - For an ACK to a read, each subsequent phy_start_stop=1 byte is driven on rsp_data with rsp_vld=1, one cycle later.
  - Delivery is capped at len+1 bytes; extra bytes are dropped and not counted.
  - The first cycle with phy_start_stop=0 ends the reply.
  - A reply carrying 0 data bytes to a read, or any reply to a write, gives rsp_bytes=0.
- DEFER handling:
  - If the retry count is below MAX_RETRY, increment it and re-enter SEND_HDR in the next cycle.
  - Otherwise finish with status 10.
- DONE:
  - Lasts one cycle: rsp_done=1 with rsp_status and rsp_bytes, then IDLE.
  - The last-grant register is updated here.
- HPD loss: hpd_signal=0 in any non-IDLE state aborts.
  - The next cycle is DONE with status 11.
  - aux_start_stop drops immediately.
- Reset mid-transaction: immediate return to reset values; no rsp_done is generated.

Test Plan:
- req0 native read (cmd=1001, addr=0x00100, len=1); sink replies 0x00,0xAA,0x55 -> aux_out 0x90,0x01,0x00,0x01; rsp_data 0xAA,0x55; rsp_done with status 00 and rsp_bytes=2.
- Both valid in the same cycle after reset -> req0 granted; on the following request pair req1 is granted; rsp_id matches the grant each time.
- req1 write (cmd=1000, len=2, data 0x11,0x22,0x33); sink replies DEFER twice then ACK -> frame sent 3 times, wr_pop asserted only on the first attempt, identical data bytes on each attempt, status 00.
- Four consecutive DEFER replies with MAX_RETRY=3 -> 4 frames sent, then rsp_done with status 10.
- No reply after a read frame -> rsp_done exactly TIMEOUT_CYCLES+1 cycles after the last aux_start_stop cycle, status 11.
- hpd_signal dropped during SEND_DATA -> aux_start_stop=0 the next cycle, then rsp_done with status 11; a request presented while hpd_signal=0 gets no ready pulse.
